// File: rtl/cpu_pkg.sv
// Shared decode constants, enums and helpers for the single-cycle RV32I core.
package cpu_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_t fmt);
    case (fmt)
      IMM_S:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm_gen = {instr[31:12], 12'b0};
      IMM_J:   imm_gen = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_gen = {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

  // Bit 30 selects SUB only for register-register ops; ADDI leaves it as immediate data.
  function automatic alu_op_t alu_op_decode(input logic [2:0] funct3, input logic alt,
                                            input logic is_reg);
    case (funct3)
      3'b000:  alu_op_decode = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_decode = ALU_SLL;
      3'b010:  alu_op_decode = ALU_SLT;
      3'b011:  alu_op_decode = ALU_SLTU;
      3'b100:  alu_op_decode = ALU_XOR;
      3'b101:  alu_op_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_decode = ALU_OR;
      default: alu_op_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cpu_core_register_file.sv
// 32x32 register file: two combinational read ports, one write port, x0 reads as zero.
module register_file
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs_reg [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_reg[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_reg[raddr2];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core: decode, ALU and next-PC are combinational from PC and Instruction.
module cpu_core
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] Instruction,
  input  logic [31:0] data_DMEM,
  output logic [9:0]  address_IMEM,
  output logic [9:0]  address_DMEM,
  output logic [31:0] write_data_DMEM,
  output logic        MemWrite,
  output logic        MemRead
);

  logic [31:0] pc_reg, pc_next, pc_plus4, pc_target;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic        alt;
  alu_op_t     alu_op;
  imm_fmt_t    imm_fmt;
  wb_sel_t     wb_sel;
  logic        alu_a_pc, alu_b_imm, reg_we;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, branch_taken;
  logic [31:0] imm, rs1_data, rs2_data, alu_a, alu_b, alu_result, wb_data;

  assign opcode = Instruction[6:0];
  assign rd     = Instruction[11:7];
  assign funct3 = Instruction[14:12];
  assign rs1    = Instruction[19:15];
  assign rs2    = Instruction[24:20];
  assign alt    = Instruction[30];

  // Unrecognised encodings fall through the defaults and behave as a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    imm_fmt   = IMM_I;
    wb_sel    = WB_ALU;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b1;
    reg_we    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_fmt = IMM_U;
        alu_op  = ALU_PASSB;
        reg_we  = 1'b1;
      end
      OP_AUIPC: begin
        imm_fmt  = IMM_U;
        alu_a_pc = 1'b1;
        reg_we   = 1'b1;
      end
      OP_JAL: begin
        imm_fmt = IMM_J;
        is_jal  = 1'b1;
        wb_sel  = WB_LINK;
        reg_we  = 1'b1;
      end
      OP_JALR: begin
        is_jalr = 1'b1;
        wb_sel  = WB_LINK;
        reg_we  = 1'b1;
      end
      OP_BRANCH: begin
        imm_fmt   = IMM_B;
        is_branch = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 == F3_WORD) begin
          is_load = 1'b1;
          wb_sel  = WB_MEM;
          reg_we  = 1'b1;
        end
      end
      OP_STORE: begin
        imm_fmt = IMM_S;
        if (funct3 == F3_WORD) begin
          is_store = 1'b1;
        end
      end
      OP_IMM: begin
        alu_op = alu_op_decode(funct3, alt, 1'b0);
        reg_we = 1'b1;
      end
      OP_REG: begin
        alu_op    = alu_op_decode(funct3, alt, 1'b1);
        alu_b_imm = 1'b0;
        reg_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm = imm_gen(Instruction, imm_fmt);

  register_file u_rf (
    .clk    (CLK),
    .rst    (RSTn),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .we     (reg_we),
    .waddr  (rd),
    .wdata  (wb_data)
  );

  assign alu_a = alu_a_pc ? pc_reg : rs1_data;
  assign alu_b = alu_b_imm ? imm : rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'b0, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $signed(alu_a) >>> shamt;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data < rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc_reg + 32'd4;
  assign pc_target = pc_reg + imm;

  always_comb begin
    pc_next = pc_plus4;
    if (is_jal || (is_branch && branch_taken)) begin
      pc_next = pc_target;
    end else if (is_jalr) begin
      pc_next = {alu_result[31:1], 1'b0};
    end
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = data_DMEM;
      WB_LINK: wb_data = pc_plus4;
      default: wb_data = alu_result;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign address_IMEM    = pc_reg[11:2];
  assign address_DMEM    = alu_result[11:2];
  assign write_data_DMEM = rs2_data;
  assign MemWrite        = is_store & ~RSTn;
  assign MemRead         = is_load & ~RSTn;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random programs checked against an ISA-level model.
module tb_cpu_core;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] Instruction, data_DMEM, write_data_DMEM;
  logic [9:0]  address_IMEM, address_DMEM;
  logic        MemWrite, MemRead;

  logic [31:0] rom [1024];
  logic [31:0] ram [1024];

  always #5 CLK = ~CLK;

  assign Instruction = rom[address_IMEM];
  assign data_DMEM   = ram[address_DMEM];

  always @(posedge CLK) begin
    if (MemWrite) ram[address_DMEM] = write_data_DMEM;
  end

  cpu_core dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .Instruction     (Instruction),
    .data_DMEM       (data_DMEM),
    .address_IMEM    (address_IMEM),
    .address_DMEM    (address_DMEM),
    .write_data_DMEM (write_data_DMEM),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead)
  );

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  localparam int NOP = 'h00000013;

  // ISA-level reference state
  logic [31:0] m_pc;
  logic [31:0] m_reg [32];
  logic [31:0] m_ram [1024];
  logic [31:0] p_pc, p_val, p_sdata;
  logic [4:0]  p_rd;
  logic [9:0]  p_addr;
  logic        p_we, p_st, p_ld;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] a, c, d, e, g;
    a = imm; c = rs1; d = f3; e = rd; g = op;
    return {a[11:0], c[4:0], d[2:0], e[4:0], g[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] a, b, c, d, e;
    a = f7; b = rs2; c = rs1; d = f3; e = rd;
    return {a[6:0], b[4:0], c[4:0], d[2:0], e[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [31:0] a, b, c, d;
    a = imm; b = rs2; c = rs1; d = f3;
    return {a[11:5], b[4:0], c[4:0], d[2:0], a[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] a, b, c, d;
    a = imm; b = rs2; c = rs1; d = f3;
    return {a[12], a[10:5], b[4:0], c[4:0], d[2:0], a[4:1], a[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] a, e;
    a = imm; e = rd;
    return {a[20], a[10:1], a[11], a[19:12], e[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    logic [31:0] a, e, g;
    a = imm20; e = rd; g = op;
    return {a[19:0], e[4:0], g[6:0]};
  endfunction

  function automatic logic [31:0] arith(logic [2:0] f3, logic alt, logic [31:0] x,
                                        logic [31:0] y, logic is_reg);
    int sh;
    sh = int'(y[4:0]);
    case (f3)
      3'd0:    return (is_reg && alt) ? x - y : x + y;
      3'd1:    return x << sh;
      3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 32'($signed(x) >>> sh) : x >> sh;
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic model_eval();
    logic [31:0] ins, a, b, i_i, i_s, i_b, i_u, i_j, ea;
    logic [2:0]  f3;
    logic        taken;
    ins = rom[m_pc[11:2]];
    f3  = ins[14:12];
    a   = m_reg[ins[19:15]];
    b   = m_reg[ins[24:20]];
    i_i = {{20{ins[31]}}, ins[31:20]};
    i_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    i_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    i_u = {ins[31:12], 12'b0};
    i_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    p_pc = m_pc + 4; p_rd = ins[11:7]; p_val = 0; p_sdata = b; p_addr = 0;
    p_we = 0; p_st = 0; p_ld = 0;
    case (ins[6:0])
      7'h37: begin p_we = 1; p_val = i_u; end
      7'h17: begin p_we = 1; p_val = m_pc + i_u; end
      7'h6F: begin p_we = 1; p_val = m_pc + 4; p_pc = m_pc + i_j; end
      7'h67: begin p_we = 1; p_val = m_pc + 4; p_pc = (a + i_i) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: taken = 0;
        endcase
        if (taken) p_pc = m_pc + i_b;
      end
      7'h03: if (f3 == 3'd2) begin
        ea = a + i_i; p_addr = ea[11:2]; p_ld = 1; p_we = 1; p_val = m_ram[p_addr];
      end
      7'h23: if (f3 == 3'd2) begin
        ea = a + i_s; p_addr = ea[11:2]; p_st = 1;
      end
      7'h13: begin p_we = 1; p_val = arith(f3, ins[30], a, i_i, 1'b0); end
      7'h33: begin p_we = 1; p_val = arith(f3, ins[30], a, b, 1'b1); end
      default: ;
    endcase
  endtask

  task automatic model_commit();
    m_pc = p_pc;
    if (p_we && p_rd != 0) m_reg[p_rd] = p_val;
    if (p_st) m_ram[p_addr] = p_sdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; one instruction retires per call.
  task automatic step();
    #1;
    model_eval();
    check("address_IMEM", {22'b0, address_IMEM}, {22'b0, m_pc[11:2]});
    check("MemWrite", {31'b0, MemWrite}, {31'b0, p_st});
    check("MemRead", {31'b0, MemRead}, {31'b0, p_ld});
    if (p_st || p_ld) check("address_DMEM", {22'b0, address_DMEM}, {22'b0, p_addr});
    if (p_st) check("write_data_DMEM", write_data_DMEM, p_sdata);
    if (verbose)
      $display("step pc=%08h ins=%08h mw=%0d mr=%0d we=%0d rd=x%0d val=%08h",
               m_pc, rom[m_pc[11:2]], p_st, p_ld, p_we, p_rd, p_val);
    @(posedge CLK);
    model_commit();
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RSTn = 1'b0;
  endtask

  task automatic check_regs_model(input string tag);
    for (int i = 1; i < 32; i++) check(tag, dut.u_rf.regs_reg[i], m_reg[i]);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin ram[i] = 0; m_ram[i] = 0; end
  endtask

  task automatic load_fib();
    for (int i = 0; i < 1024; i++) rom[i] = NOP;
    rom[0]  = enc_i(0, 0, 0, 1, 'h13);
    rom[1]  = enc_i(1, 0, 0, 2, 'h13);
    rom[2]  = enc_i(0, 0, 0, 3, 'h13);
    rom[3]  = enc_i(12, 0, 0, 4, 'h13);
    rom[4]  = enc_s(0, 1, 3, 2);
    rom[5]  = enc_r(0, 2, 1, 0, 5);
    rom[6]  = enc_i(0, 2, 0, 1, 'h13);
    rom[7]  = enc_i(0, 5, 0, 2, 'h13);
    rom[8]  = enc_i(4, 3, 0, 3, 'h13);
    rom[9]  = enc_i(-1, 4, 0, 4, 'h13);
    rom[10] = enc_b(-24, 0, 4, 1);
    rom[11] = enc_j(0, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rd, rs1, rs2, f3, imm;
    k   = int'($urandom_range(0, 15));
    rd  = int'($urandom_range(0, 31));
    rs1 = int'($urandom_range(0, 31));
    rs2 = int'($urandom_range(0, 31));
    f3  = int'($urandom_range(0, 7));
    imm = int'($urandom_range(0, 4095)) - 2048;
    case (k)
      0, 1, 2: begin
        if (f3 == 1) imm = int'($urandom_range(0, 31));
        if (f3 == 5) imm = int'($urandom_range(0, 31)) + ($urandom_range(0, 1) != 0 ? 'h400 : 0);
        return enc_i(imm, rs1, f3, rd, 'h13);
      end
      3, 4, 5: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) != 0) ? 32 : 0,
                            rs2, rs1, f3, rd);
      6: return enc_u(int'($urandom_range(0, 'hFFFFF)), rd, 'h37);
      7: return enc_u(int'($urandom_range(0, 'hFFFFF)), rd, 'h17);
      8: begin
        case ($urandom_range(0, 5))
          0: f3 = 0; 1: f3 = 1; 2: f3 = 4; 3: f3 = 5; 4: f3 = 6; default: f3 = 7;
        endcase
        return enc_b(int'($urandom_range(1, 16)) * 4 * ($urandom_range(0, 1) != 0 ? 1 : -1),
                     rs2, rs1, f3);
      end
      9:  return enc_j(int'($urandom_range(1, 64)) * 4 * ($urandom_range(0, 1) != 0 ? 1 : -1), rd);
      10: return enc_i(imm, rs1, 0, rd, 'h67);
      11: return enc_i(imm, rs1, 2, rd, 'h03);
      12: return enc_s(imm, rs2, rs1, 2);
      13: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000000F;
          1: return 32'h00000073;
          2: return enc_i(imm, rs1, 0, rd, 'h03);
          3: return enc_i(imm, rs1, 1, rd, 'h03);
          default: return enc_s(imm, rs2, rs1, 0);
        endcase
      end
      default: return enc_i(int'($urandom_range(0, 64)) - 32, rs1, 0, rd, 'h13);
    endcase
  endfunction

  initial begin
    // reset state, with a store sitting at ROM[0]
    for (int i = 0; i < 1024; i++) rom[i] = NOP;
    rom[0] = enc_s(8, 1, 0, 2);
    RSTn = 1'b0;
    #1 RSTn = 1'b1;
    #2;
    check("rst_address_IMEM", {22'b0, address_IMEM}, 32'd0);
    check("rst_MemWrite", {31'b0, MemWrite}, 32'd0);
    check("rst_MemRead", {31'b0, MemRead}, 32'd0);
    for (int i = 1; i < 32; i++) check("rst_reg_zero", dut.u_rf.regs_reg[i], 32'd0);

    // directed: arithmetic, store/load, branches, jumps
    clear_mem();
    model_reset();
    rom[0]  = enc_i(5, 0, 0, 1, 'h13);
    rom[1]  = enc_i(-3, 0, 0, 2, 'h13);
    rom[2]  = enc_r(0, 2, 1, 0, 3);
    rom[3]  = enc_r(32, 2, 1, 0, 4);
    rom[4]  = enc_s(8, 1, 0, 2);
    rom[5]  = enc_i(8, 0, 2, 5, 'h03);
    rom[6]  = enc_i(-1, 0, 0, 6, 'h13);
    rom[7]  = enc_i(1, 0, 0, 7, 'h13);
    rom[8]  = enc_b(12, 1, 1, 0);
    rom[9]  = enc_i(99, 0, 0, 8, 'h13);
    rom[10] = enc_i(99, 0, 0, 8, 'h13);
    rom[11] = enc_b(8, 1, 1, 1);
    rom[12] = enc_b(8, 7, 6, 4);
    rom[13] = enc_i(99, 0, 0, 8, 'h13);
    rom[14] = enc_b(8, 7, 6, 6);
    rom[15] = NOP;
    rom[16] = enc_j(16, 1);
    rom[17] = enc_j(0, 0);
    rom[20] = enc_i(0, 1, 0, 0, 'h67);
    release_reset();
    run(9);
    check("beq_taken_pc", {22'b0, address_IMEM}, 32'h2C >> 2);
    run(21);
    check("x3_add", dut.u_rf.regs_reg[3], 32'd2);
    check("x4_sub", dut.u_rf.regs_reg[4], 32'd8);
    check("x5_lw", dut.u_rf.regs_reg[5], 32'd5);
    check("x1_link", dut.u_rf.regs_reg[1], 32'h44);
    check("x8_skipped", dut.u_rf.regs_reg[8], 32'd0);
    check("ram2_sw", ram[2], 32'd5);
    check("jalr_loop_pc", {22'b0, address_IMEM}, 32'h44 >> 2);
    check_regs_model("directed_regs");

    // Fibonacci into RAM words 0..11
    RSTn = 1'b1;
    clear_mem();
    model_reset();
    load_fib();
    release_reset();
    verbose = 1'b0;
    run(300);
    $display("fib ram[10]=%0d ram[11]=%0d", ram[10], ram[11]);
    check("fib_ram11", ram[11], 32'd89);
    check("fib_ram10", ram[10], 32'd55);
    check("fib_ram7", ram[7], 32'd13);
    check("fib_loop_memwrite", {31'b0, MemWrite}, 32'd0);
    check("fib_loop_pc", {22'b0, address_IMEM}, 32'd11);

    // asynchronous reset in the middle of a cycle
    @(posedge CLK);
    #3 RSTn = 1'b1;
    #1;
    check("midrst_address_IMEM", {22'b0, address_IMEM}, 32'd0);
    check("midrst_MemWrite", {31'b0, MemWrite}, 32'd0);
    for (int i = 1; i < 32; i++) check("midrst_reg_zero", dut.u_rf.regs_reg[i], 32'd0);
    $display("mid-program reset applied");
    clear_mem();
    model_reset();
    release_reset();
    run(300);
    check("restart_ram11", ram[11], 32'd89);
    check_regs_model("restart_regs");

    // random programs against the reference model
    for (int seg = 0; seg < 3; seg++) begin
      int bad;
      RSTn = 1'b1;
      for (int i = 0; i < 1024; i++) begin
        rom[i] = rand_instr();
        ram[i] = $urandom;
        m_ram[i] = ram[i];
      end
      model_reset();
      release_reset();
      run(500);
      check_regs_model("random_regs");
      bad = 0;
      for (int i = 0; i < 1024; i++) if (ram[i] !== m_ram[i]) bad++;
      check("random_ram_words_differing", bad, 0);
      $display("random segment %0d done pc=%08h", seg, m_pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
